// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Brief    : Time-multiplexed scan controller for a multi-digit 7-segment
//            display sharing one registered binary_to_7segment decoder.
//            Optional leading-zero suppression: SEVEN_SEG_SCANNER_LZ_BLANK_EN
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [3:0]              o_dec_bin,
    input  logic [6:0]              i_dec_seg,
    output logic [6:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame
);

    localparam int c_IDX_W   = $clog2(NUM_DIGITS);
    localparam int c_CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BLANK = 2'd1;
    localparam logic [1:0] c_ST_SHOW  = 2'd2;

    localparam logic [NUM_DIGITS-1:0] c_AN_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_CNT_W-1:0]    c_BLANK_END = c_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_DWELL_END = c_CNT_W'(DWELL_CYCLES - 1);

    logic [1:0]              r_state,   w_state;
    logic [c_IDX_W-1:0]      r_index,   w_index;
    logic [c_CNT_W-1:0]      r_count,   w_count;
    logic [4*NUM_DIGITS-1:0] r_active,  w_active;
    logic [4*NUM_DIGITS-1:0] r_shadow,  w_shadow;
    logic                    r_pending, w_pending;
    logic [3:0]              r_dec_bin, w_dec_bin;
    logic [6:0]              r_seg,     w_seg;
    logic [NUM_DIGITS-1:0]   r_an,      w_an;
    logic                    r_frame,   w_frame;

    logic w_accept;
    logic w_boundary;
    logic w_enter_blank;
    logic w_lit;

    assign w_accept = i_valid && !r_pending;

`ifdef SEVEN_SEG_SCANNER_LZ_BLANK_EN
    // A digit is dark when it and every more-significant nibble are zero.
    assign w_lit = (r_index == '0) || ((r_active >> {r_index, 2'b00}) != '0);
`else
    assign w_lit = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= c_ST_BLANK;
            r_index   <= '0;
            r_count   <= '0;
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_dec_bin <= '0;
            r_seg     <= '0;
            r_an      <= '0;
            r_frame   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_index   <= w_index;
            r_count   <= w_count;
            r_active  <= w_active;
            r_shadow  <= w_shadow;
            r_pending <= w_pending;
            r_dec_bin <= w_dec_bin;
            r_seg     <= w_seg;
            r_an      <= w_an;
            r_frame   <= w_frame;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_index       = r_index;
        w_count       = r_count;
        w_active      = r_active;
        w_shadow      = r_shadow;
        w_pending     = r_pending;
        w_dec_bin     = r_dec_bin;
        w_seg         = r_seg;
        w_an          = r_an;
        w_frame       = 1'b0;
        w_boundary    = 1'b0;
        w_enter_blank = 1'b0;

        if (!i_enable) begin
            w_state = c_ST_IDLE;
            w_index = '0;
            w_count = '0;
            w_an    = '0;
            w_seg   = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_index       = '0;
                    w_boundary    = 1'b1;
                    w_enter_blank = 1'b1;
                end
                c_ST_BLANK: begin
                    if (r_count == c_BLANK_END) begin
                        // Decoder output has settled for this digit by now.
                        w_state = c_ST_SHOW;
                        w_count = '0;
                        w_seg   = i_dec_seg;
                        w_an    = w_lit ? (c_AN_ONE << r_index) : '0;
                    end else begin
                        w_count = r_count + 1'b1;
                    end
                end
                c_ST_SHOW: begin
                    if (r_count == c_DWELL_END) begin
                        w_enter_blank = 1'b1;
                        if (r_index == c_IDX_LAST) begin
                            w_index    = '0;
                            w_boundary = 1'b1;
                        end else begin
                            w_index = r_index + 1'b1;
                        end
                    end else begin
                        w_count = r_count + 1'b1;
                    end
                end
                default: begin
                    w_state = c_ST_IDLE;
                end
            endcase
        end

        // Capture and apply are mutually exclusive: capture needs pending low.
        if (w_accept) begin
            w_shadow  = i_value;
            w_pending = 1'b1;
        end
        if (w_boundary && r_pending) begin
            w_active  = r_shadow;
            w_pending = 1'b0;
        end

        if (w_enter_blank) begin
            w_state   = c_ST_BLANK;
            w_count   = '0;
            w_seg     = '0;
            w_an      = '0;
            w_dec_bin = w_active[{w_index, 2'b00} +: 4];
            w_frame   = w_boundary;
        end
    end

    assign o_ready   = !r_pending;
    assign o_dec_bin = r_dec_bin;
    assign o_seg     = r_seg;
    assign o_an      = r_an;
    assign o_frame   = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scanner
// Brief    : Scoreboard bench for seven_seg_scanner with a registered decoder
//            model; honours SEVEN_SEG_SCANNER_LZ_BLANK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

    localparam int c_ND    = 4;
    localparam int c_DW    = 4;
    localparam int c_BL    = 2;
    localparam int c_SLOT  = c_BL + c_DW;
    localparam int c_FRAME = c_ND * c_SLOT;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        en      = 1'b0;
    logic        valid   = 1'b0;
    logic [15:0] value   = '0;
    logic [6:0]  dec_seg = '0;
    logic        o_ready;
    logic [3:0]  o_dec_bin;
    logic [6:0]  o_seg;
    logic [3:0]  o_an;
    logic        o_frame;

    int tests = 0;
    int fails = 0;

    seven_seg_scanner #(
        .NUM_DIGITS   (c_ND),
        .DWELL_CYCLES (c_DW),
        .BLANK_CYCLES (c_BL)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_enable  (en),
        .i_value   (value),
        .i_valid   (valid),
        .o_ready   (o_ready),
        .o_dec_bin (o_dec_bin),
        .i_dec_seg (dec_seg),
        .o_seg     (o_seg),
        .o_an      (o_an),
        .o_frame   (o_frame)
    );

    always #5 clk = ~clk;

    // Segment order {a,b,c,d,e,f,g}, a in the MSB.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h7E; 4'h1: seg_of = 7'h30; 4'h2: seg_of = 7'h6D; 4'h3: seg_of = 7'h79;
            4'h4: seg_of = 7'h33; 4'h5: seg_of = 7'h5B; 4'h6: seg_of = 7'h5F; 4'h7: seg_of = 7'h70;
            4'h8: seg_of = 7'h7F; 4'h9: seg_of = 7'h7B; 4'hA: seg_of = 7'h77; 4'hB: seg_of = 7'h1F;
            4'hC: seg_of = 7'h4E; 4'hD: seg_of = 7'h3D; 4'hE: seg_of = 7'h4F; default: seg_of = 7'h47;
        endcase
    endfunction

    always @(posedge clk) dec_seg <= seg_of(o_dec_bin);

    // Edge counter and the control inputs as sampled on the latest edge.
    int   cyc   = 0;
    logic rst_s = 1'b1;
    logic en_s  = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
        en_s  <= en;
    end

    typedef struct {
        logic [15:0] v;
        int          edge_n;
    } acc_t;
    acc_t acc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    int          phase    = 0;
    bit          idle     = 1'b0;
    bit          exp_fr   = 1'b0;
    bit          lit      = 1'b0;
    int          slot     = 0;
    int          off      = 0;
    int          npend    = 0;
    logic [3:0]  nib      = '0;
    logic [15:0] m_active = '0;
    acc_t        head;

    always @(negedge clk) begin
        if (rst_s) begin
            while (acc_q.size() > 0 && acc_q[0].edge_n <= cyc) void'(acc_q.pop_front());
            m_active = '0;
            phase    = 0;
            idle     = 1'b0;
            chk("rst_an",    32'(o_an),      32'h0);
            chk("rst_seg",   32'(o_seg),     32'h0);
            chk("rst_dec",   32'(o_dec_bin), 32'h0);
            chk("rst_frame", 32'(o_frame),   32'h0);
            chk("rst_ready", 32'(o_ready),   32'h1);
        end else begin
            if (!en_s) begin
                idle = 1'b1;
                chk("idle_an",    32'(o_an),    32'h0);
                chk("idle_seg",   32'(o_seg),   32'h0);
                chk("idle_frame", 32'(o_frame), 32'h0);
            end else begin
                if (idle) begin
                    idle   = 1'b0;
                    phase  = 0;
                    exp_fr = 1'b1;
                end else begin
                    phase  = phase + 1;
                    exp_fr = 1'b0;
                    if (phase == c_FRAME) begin
                        phase  = 0;
                        exp_fr = 1'b1;
                    end
                end
                chk("frame", 32'(o_frame), 32'(exp_fr));
                if (exp_fr && acc_q.size() > 0 && acc_q[0].edge_n < cyc) begin
                    head     = acc_q.pop_front();
                    m_active = head.v;
                end
                slot = phase / c_SLOT;
                off  = phase % c_SLOT;
                nib  = 4'((m_active >> (4 * slot)) & 16'hF);
`ifdef SEVEN_SEG_SCANNER_LZ_BLANK_EN
                lit = (slot == 0) || ((m_active >> (4 * slot)) != 16'h0);
`else
                lit = 1'b1;
`endif
                chk("dec_bin", 32'(o_dec_bin), 32'(nib));
                if (off < c_BL) begin
                    chk("blank_an",  32'(o_an),  32'h0);
                    chk("blank_seg", 32'(o_seg), 32'h0);
                end else begin
                    chk("show_an",  32'(o_an),  lit ? (32'h1 << slot) : 32'h0);
                    chk("show_seg", 32'(o_seg), 32'(seg_of(nib)));
                end
            end
            npend = 0;
            foreach (acc_q[i]) if (acc_q[i].edge_n <= cyc) npend++;
            chk("ready", 32'(o_ready), (npend == 0) ? 32'h1 : 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] v);
        valid = 1'b1;
        value = v;
        if (o_ready) acc_q.push_back('{v, cyc + 1});
        step(1);
        valid = 1'b0;
        value = $urandom;
    endtask

    task automatic wait_an(input logic [3:0] pat, input int budget);
        int k;
        k = 0;
        while (o_an !== pat && k < budget) begin
            step(1);
            k++;
        end
        tests++;
        if (o_an !== pat) begin
            fails++;
            $display("FAIL wait_an: o_an=%b after %0d cycles, expected %b", o_an, k, pat);
        end
    endtask

    initial begin
        logic [15:0] rv;
        int r;
        rst = 1'b1; en = 1'b1;
        step(4);
        rst = 1'b0; en = 1'b0;
        step(2);
        offer(16'h1234);
        en = 1'b1;
        step(30);
        wait_an(4'b0010, 40);
        offer(16'hABCD);
        step(40);
        wait_an(4'b0100, 40);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(10);
        wait_an(4'b0100, 40);
        offer(16'h9999);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(30);
        offer(16'h0007);
        step(50);
        offer(16'h0000);
        step(30);
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 19);
            if (r < 8) begin
                rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
                offer(rv);
            end else if (r < 10) begin
                en = 1'b0;
                step($urandom_range(1, 5));
                en = 1'b1;
            end else if (r == 10) begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end else begin
                step($urandom_range(1, 10));
            end
        end
        step(30);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
